scmp_useq: RTL

- Parametrised microcode sequencer: next generation of the SC/MP microcode program counter logic.
- Generalised in PC width, displacement width and condition width.
- Adds a call/return stack of configurable depth, a bus-wait stall, and a trap dispatch at the decode point.
- Owns only mc_pc sequencing. The external microcode PLA decodes mc_pc combinationally into the uw_* fields in the same cycle.

---
 rtl/scmp_useq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/scmp_useq.sv
// Microcode sequencer for the SC/MP family: owns mc_pc, a small return stack,
// a bus-wait stall and trap dispatch at the opcode decode point.
module scmp_useq #(
  parameter int              PC_W     = 8,
  parameter int              DISP_W   = 5,
  parameter int              COND_W   = 4,
  parameter int              STK_D    = 4,
  parameter logic [PC_W-1:0] FETCH_PC = '0,
  parameter logic [PC_W-1:0] TRAP_PC  = 8'hF0,
  localparam int             SP_W     = $clog2(STK_D + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DISP_W-1:0] uw_next,
  input  logic [COND_W-1:0] uw_condm,
  input  logic [COND_W-1:0] uw_condx,
  input  logic              uw_decode,
  input  logic              uw_call,
  input  logic              uw_ret,
  input  logic              uw_wait,
  input  logic [COND_W-1:0] cond_in,
  input  logic [PC_W-1:0]   op_pc,
  input  logic              bus_rdy,
  input  logic              trap_req,
  output logic [PC_W-1:0]   mc_pc,
  output logic              trap_ack,
  output logic [SP_W-1:0]   sp_lvl,
  output logic              stk_ovf,
  output logic              stk_unf
);

  localparam int              IDX_W   = (STK_D > 1) ? $clog2(STK_D) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STK_D);

  typedef enum logic [2:0] {
    ACT_STALL,
    ACT_DECODE,
    ACT_RET,
    ACT_SKIP,
    ACT_CALL,
    ACT_HOME,
    ACT_JUMP
  } act_e;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            ack_q, ack_d;
  logic [PC_W-1:0] stk_q [2**IDX_W];

  logic            cond;
  act_e            act;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_rel;
  logic [SP_W-1:0] sp_dec;
  logic [IDX_W-1:0] pop_idx;
  logic [IDX_W-1:0] push_idx;
  logic            push_en;

  assign cond     = |((cond_in ^ uw_condx) & uw_condm);
  assign pc_inc   = pc_q + 1'b1;
  assign pc_rel   = pc_q + {{(PC_W - DISP_W){uw_next[DISP_W-1]}}, uw_next};
  assign sp_dec   = sp_q - 1'b1;
  assign pop_idx  = sp_dec[IDX_W-1:0];
  assign push_idx = sp_q[IDX_W-1:0];

  // First matching rule wins; the order is the architectural priority.
  always_comb begin
    if (uw_wait && !bus_rdy) act = ACT_STALL;
    else if (uw_decode)      act = ACT_DECODE;
    else if (uw_ret)         act = ACT_RET;
    else if (cond)           act = ACT_SKIP;
    else if (uw_call)        act = ACT_CALL;
    else if (uw_next == '0)  act = ACT_HOME;
    else                     act = ACT_JUMP;
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    ack_d   = 1'b0;
    push_en = 1'b0;
    unique case (act)
      ACT_STALL: ;
      ACT_DECODE: begin
        if (trap_req) begin
          pc_d  = TRAP_PC;
          ack_d = 1'b1;
        end else begin
          pc_d = op_pc;
        end
      end
      ACT_RET: begin
        if (sp_q != '0) begin
          pc_d = stk_q[pop_idx];
          sp_d = sp_dec;
        end else begin
          pc_d  = FETCH_PC;
          unf_d = 1'b1;
        end
      end
      ACT_SKIP: pc_d = pc_inc;
      ACT_CALL: begin
        pc_d = (uw_next == '0) ? FETCH_PC : pc_rel;
        if (sp_q == SP_FULL) begin
          ovf_d = 1'b1;
        end else begin
          push_en = 1'b1;
          sp_d    = sp_q + 1'b1;
        end
      end
      ACT_HOME: pc_d = FETCH_PC;
      ACT_JUMP: pc_d = pc_rel;
      default:  ;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= FETCH_PC;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      ack_q <= ack_d;
    end
  end

  // NOTE: stack entries are deliberately not reset; sp_q alone defines which
  // entries are valid, so the storage can map onto plain register-file cells.
  always_ff @(posedge clk) begin
    if (push_en) stk_q[push_idx] <= pc_inc;
  end

  assign mc_pc    = pc_q;
  assign sp_lvl   = sp_q;
  assign stk_ovf  = ovf_q;
  assign stk_unf  = unf_q;
  assign trap_ack = ack_q;

endmodule
